// File: rtl/paq_busqueda.sv
// Shared definitions for the instruction fetch stage.
//   estado_t  : fetch FSM states (BUSCA = fetching, DRENA = dropping stale responses)
//   INCR_PC   : byte increment between consecutive instructions
//   entrada_t : default FIFO entry {word, pc} at 32-bit width
//   pc_sig    : next sequential PC, wrapping modulo 2^32
package paq_busqueda;

  typedef enum logic {
    BUSCA = 1'b0,
    DRENA = 1'b1
  } estado_t;

  localparam int unsigned INCR_PC = 4;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entrada_t;

  function automatic logic [31:0] pc_sig(input logic [31:0] pc);
    return pc + 32'(INCR_PC);
  endfunction

endpackage

// File: rtl/fifo_inst.sv
// Synchronous instruction FIFO holding {word, pc} entries.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   push/pop   : write dato_in / advance head; ignored when full/empty
//   flush      : empties the FIFO, overriding any push/pop in the same cycle
//   dato_out   : head entry (only meaningful when ocupacion != 0)
//   ocupacion  : number of stored entries, 0..PROF
module fifo_inst
  import paq_busqueda::*;
#(
  parameter int unsigned PROF = 4,
  parameter type T = entrada_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  T                         dato_in,
  output T                         dato_out,
  output logic [$clog2(PROF):0]    ocupacion
);

  localparam int unsigned PW = $clog2(PROF);
  localparam int unsigned CW = PW + 1;

  T               mem [PROF];
  logic [PW-1:0]  rd;
  logic [PW-1:0]  wr;
  logic [CW-1:0]  cnt;
  logic           do_push;
  logic           do_pop;

  always_comb begin
    do_push = push && (cnt != CW'(PROF)) && !flush;
    do_pop  = pop  && (cnt != '0)        && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else if (flush) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + PW'(1);
      if (do_pop)  rd <= rd + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= dato_in;
  end

  assign dato_out  = mem[rd];
  assign ocupacion = cnt;

endmodule

// File: rtl/etapa_busqueda.sv
// Instruction fetch stage: owns the PC, issues in-order fetches to a
// variable-latency memory, buffers returned words and hands them to decode.
//   CLK, RSTn                 : clock, asynchronous active-low reset
//   MemReq/MemDir/MemAck      : fetch request channel (MemDir = current PC)
//   MemValido/MemDato         : in-order response channel
//   Salto/DirSalto            : redirect pulse and target
//   InstValida/Inst/InstPC    : instruction to decode (zeros when not valid)
//   InstListo                 : decode consumes the head entry
module etapa_busqueda
  import paq_busqueda::*;
#(
  parameter int unsigned         ANCHO    = 32,
  parameter int unsigned         PROF     = 4,
  parameter logic [ANCHO-1:0]    PC_RESET = '0
) (
  input  logic             CLK,
  input  logic             RSTn,
  output logic             MemReq,
  output logic [ANCHO-1:0] MemDir,
  input  logic             MemAck,
  input  logic             MemValido,
  input  logic [ANCHO-1:0] MemDato,
  input  logic             Salto,
  input  logic [ANCHO-1:0] DirSalto,
  output logic             InstValida,
  output logic [ANCHO-1:0] Inst,
  output logic [ANCHO-1:0] InstPC,
  input  logic             InstListo
);

  localparam int unsigned CW = $clog2(PROF) + 1;

  typedef struct packed {
    logic [ANCHO-1:0] word;
    logic [ANCHO-1:0] pc;
  } entrada_w_t;

  estado_t          estado, estado_n;
  logic [ANCHO-1:0] pc, pc_n;
  logic [ANCHO-1:0] pc_resp, pc_resp_n;
  logic [CW-1:0]    pendientes, pendientes_n;
  logic [CW-1:0]    descartar, descartar_n;
  logic [CW-1:0]    ocupacion;
  logic [CW-1:0]    stale;
  logic [CW:0]      suma;
  logic             arrancado;
  logic             req;
  logic             acepta;
  logic             resp_buena;
  logic             push;
  logic             pop;
  logic             flush;
  entrada_w_t       entrada_in;
  entrada_w_t       cabeza;

  // arrancado keeps MemReq low while in reset and for the release cycle,
  // so requests start on the first full cycle after RSTn rises.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      estado     <= BUSCA;
      pc         <= PC_RESET;
      pc_resp    <= PC_RESET;
      pendientes <= '0;
      descartar  <= '0;
      arrancado  <= 1'b0;
    end else begin
      estado     <= estado_n;
      pc         <= pc_n;
      pc_resp    <= pc_resp_n;
      pendientes <= pendientes_n;
      descartar  <= descartar_n;
      arrancado  <= 1'b1;
    end
  end

  always_comb begin
    // Credit: buffered words plus outstanding fetches never exceed PROF,
    // so every accepted response has a FIFO slot waiting for it.
    suma       = {1'b0, ocupacion} + {1'b0, pendientes};
    req        = arrancado && (estado == BUSCA) && (suma < (CW+1)'(PROF));
    acepta     = req && MemAck;
    resp_buena = (estado == BUSCA) && MemValido && (pendientes != '0);
    stale      = pendientes + CW'(acepta) - CW'(resp_buena);

    estado_n     = estado;
    pc_n         = pc;
    pc_resp_n    = pc_resp;
    pendientes_n = pendientes;
    descartar_n  = descartar;
    push         = 1'b0;
    flush        = 1'b0;

    unique case (estado)
      BUSCA: begin
        if (acepta) pc_n = pc + ANCHO'(INCR_PC);
        pendientes_n = stale;
        if (resp_buena) begin
          push      = 1'b1;
          pc_resp_n = pc_resp + ANCHO'(INCR_PC);
        end
        if (Salto) begin
          pc_n      = DirSalto;
          pc_resp_n = DirSalto;
          flush     = 1'b1;
          if (stale != '0) begin
            descartar_n  = stale;
            pendientes_n = '0;
            estado_n     = DRENA;
          end
        end
      end
      DRENA: begin
        if (MemValido && (descartar != '0)) begin
          descartar_n = descartar - CW'(1);
          if (descartar == CW'(1)) estado_n = BUSCA;
        end
        if (Salto) begin
          pc_n      = DirSalto;
          pc_resp_n = DirSalto;
          flush     = 1'b1;
        end
      end
      default: estado_n = BUSCA;
    endcase
  end

  always_comb begin
    entrada_in.word = MemDato;
    entrada_in.pc   = pc_resp;
    pop             = InstValida && InstListo;
  end

  fifo_inst #(
    .PROF (PROF),
    .T    (entrada_w_t)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RSTn),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .dato_in   (entrada_in),
    .dato_out  (cabeza),
    .ocupacion (ocupacion)
  );

  assign MemReq     = req;
  assign MemDir     = pc;
  assign InstValida = (ocupacion != '0);
  assign Inst       = InstValida ? cabeza.word : '0;
  assign InstPC     = InstValida ? cabeza.pc   : '0;

endmodule

// File: tb/tb_etapa_busqueda.sv
module tb_etapa_busqueda;

  logic        CLK;
  logic        RSTn;
  logic        MemReq;
  logic [31:0] MemDir;
  logic        MemAck;
  logic        MemValido;
  logic [31:0] MemDato;
  logic        Salto;
  logic [31:0] DirSalto;
  logic        InstValida;
  logic [31:0] Inst;
  logic [31:0] InstPC;
  logic        InstListo;

  int unsigned n_total = 0;
  int unsigned n_fallos = 0;

  // memory model state
  logic [31:0] q_dir[$];
  int unsigned q_due[$];
  int unsigned ciclo = 0;
  int unsigned lat = 1;
  int unsigned n_acept = 0;

  // delivered instruction log
  logic [31:0] ent_pc[$];
  logic [31:0] ent_inst[$];
  int unsigned base = 0;
  int unsigned na0 = 0;

  etapa_busqueda #(
    .ANCHO    (32),
    .PROF     (4),
    .PC_RESET (32'h0000_0000)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .MemReq     (MemReq),
    .MemDir     (MemDir),
    .MemAck     (MemAck),
    .MemValido  (MemValido),
    .MemDato    (MemDato),
    .Salto      (Salto),
    .DirSalto   (DirSalto),
    .InstValida (InstValida),
    .Inst       (Inst),
    .InstPC     (InstPC),
    .InstListo  (InstListo)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // In-order memory: accept seen in cycle c answers in cycle c+lat.
  // Data word is address ^ 0xA5A5_0000.
  initial begin
    MemValido = 1'b0;
    MemDato   = '0;
    forever begin
      @(negedge CLK);
      if (InstValida && InstListo) begin
        ent_pc.push_back(InstPC);
        ent_inst.push_back(Inst);
      end
      if (MemReq && MemAck) begin
        q_dir.push_back(MemDir);
        q_due.push_back(ciclo + lat);
        n_acept++;
      end
      if (q_dir.size() > 0 && q_due[0] <= ciclo) begin
        MemValido = 1'b1;
        MemDato   = q_dir[0] ^ 32'hA5A5_0000;
        void'(q_dir.pop_front());
        void'(q_due.pop_front());
      end else begin
        MemValido = 1'b0;
        MemDato   = '0;
      end
      ciclo++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fallos++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int unsigned i);
    if (i < ent_pc.size()) return ent_pc[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tic();
    @(posedge CLK);
    #1;
  endtask

  // Holds reset a few cycles, releases it, and returns in the first
  // full cycle after release (cycle 0 of the new stream).
  task automatic reinicia(input int unsigned l);
    RSTn      = 1'b0;
    Salto     = 1'b0;
    DirSalto  = '0;
    MemAck    = 1'b1;
    InstListo = 1'b1;
    lat       = l;
    repeat (5) tic();
    RSTn = 1'b1;
    tic();
    base = ent_pc.size();
    na0  = n_acept;
  endtask

  initial begin
    RSTn      = 1'b1;
    MemAck    = 1'b1;
    Salto     = 1'b0;
    DirSalto  = '0;
    InstListo = 1'b1;
    #2 RSTn = 1'b0;
    #1;
    chk("rst_memreq", 32'(MemReq), 32'd0);
    chk("rst_memdir", MemDir, 32'h0);
    chk("rst_valida", 32'(InstValida), 32'd0);
    chk("rst_inst", Inst, 32'h0);
    chk("rst_instpc", InstPC, 32'h0);

    // back-to-back stream, 1-cycle memory
    reinicia(1);
    chk("s1_c0_req", 32'(MemReq), 32'd1);
    chk("s1_c0_dir", MemDir, 32'h0);
    tic();
    chk("s1_c1_dir", MemDir, 32'h4);
    chk("s1_c1_valida", 32'(InstValida), 32'd0);
    tic();
    for (int k = 0; k < 6; k++) begin
      chk("s1_valida", 32'(InstValida), 32'd1);
      chk("s1_pc", InstPC, 32'(4 * k));
      chk("s1_inst", Inst, 32'(4 * k) ^ 32'hA5A5_0000);
      tic();
    end

    // decode stalled: credit stops requests after 4
    reinicia(1);
    InstListo = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("s2_req", 32'(MemReq), 32'd1);
      chk("s2_dir", MemDir, 32'(4 * c));
      tic();
    end
    chk("s2_c4_req", 32'(MemReq), 32'd0);
    tic();
    chk("s2_c5_req", 32'(MemReq), 32'd0);
    tic();
    chk("s2_c6_req", 32'(MemReq), 32'd0);
    chk("s2_c6_pc", InstPC, 32'h0);
    chk("s2_nreq", n_acept - na0, 32'd4);
    InstListo = 1'b1;
    tic();
    chk("s2_c7_req", 32'(MemReq), 32'd1);
    chk("s2_c7_dir", MemDir, 32'h10);
    repeat (6) tic();
    for (int i = 0; i < 5; i++) chk("s2_orden", ent(base + i), 32'(4 * i));

    // redirect with 2 outstanding, 3-cycle memory
    reinicia(3);
    tic();
    tic();
    chk("s3_c2_dir", MemDir, 32'h8);
    MemAck = 1'b0;
    Salto = 1'b1;
    DirSalto = 32'h100;
    tic();
    Salto = 1'b0;
    MemAck = 1'b1;
    chk("s3_c3_req", 32'(MemReq), 32'd0);
    chk("s3_c3_valida", 32'(InstValida), 32'd0);
    tic();
    chk("s3_c4_req", 32'(MemReq), 32'd0);
    tic();
    chk("s3_c5_req", 32'(MemReq), 32'd1);
    chk("s3_c5_dir", MemDir, 32'h100);
    repeat (3) tic();
    chk("s3_c8_valida", 32'(InstValida), 32'd0);
    tic();
    chk("s3_c9_valida", 32'(InstValida), 32'd1);
    chk("s3_c9_pc", InstPC, 32'h100);
    chk("s3_c9_inst", Inst, 32'hA5A5_0100);
    tic();
    chk("s3_primera", ent(base), 32'h100);

    // redirect with nothing outstanding, 3 words buffered
    reinicia(1);
    InstListo = 1'b0;
    repeat (3) tic();
    MemAck = 1'b0;
    tic();
    chk("s4_c4_pc", InstPC, 32'h0);
    chk("s4_c4_dir", MemDir, 32'hC);
    Salto = 1'b1;
    DirSalto = 32'h200;
    tic();
    Salto = 1'b0;
    chk("s4_c5_valida", 32'(InstValida), 32'd0);
    chk("s4_c5_req", 32'(MemReq), 32'd1);
    chk("s4_c5_dir", MemDir, 32'h200);
    MemAck = 1'b1;
    InstListo = 1'b1;
    tic();
    chk("s4_c6_valida", 32'(InstValida), 32'd0);
    tic();
    chk("s4_c7_pc", InstPC, 32'h200);
    chk("s4_c7_inst", Inst, 32'hA5A5_0200);

    // redirect coinciding with accept and response, 1 outstanding
    reinicia(1);
    repeat (3) tic();
    chk("s5_c3_pc", InstPC, 32'h4);
    Salto = 1'b1;
    DirSalto = 32'h300;
    tic();
    Salto = 1'b0;
    chk("s5_c4_req", 32'(MemReq), 32'd0);
    chk("s5_c4_valida", 32'(InstValida), 32'd0);
    tic();
    chk("s5_c5_req", 32'(MemReq), 32'd1);
    chk("s5_c5_dir", MemDir, 32'h300);
    tic();
    chk("s5_c6_valida", 32'(InstValida), 32'd0);
    tic();
    chk("s5_c7_pc", InstPC, 32'h300);
    tic();
    chk("s5_nent", ent_pc.size() - base, 32'd3);
    chk("s5_e0", ent(base), 32'h0);
    chk("s5_e1", ent(base + 1), 32'h4);
    chk("s5_e2", ent(base + 2), 32'h300);

    // reset asserted while draining
    reinicia(3);
    tic();
    tic();
    MemAck = 1'b0;
    Salto = 1'b1;
    DirSalto = 32'h100;
    tic();
    Salto = 1'b0;
    MemAck = 1'b1;
    chk("s6_dir_drena", MemDir, 32'h100);
    RSTn = 1'b0;
    #1;
    chk("s6_rst_req", 32'(MemReq), 32'd0);
    chk("s6_rst_dir", MemDir, 32'h0);
    chk("s6_rst_valida", 32'(InstValida), 32'd0);
    chk("s6_rst_inst", Inst, 32'h0);
    chk("s6_rst_pc", InstPC, 32'h0);
    tic();
    RSTn = 1'b1;
    tic();
    chk("s6_n0_req", 32'(MemReq), 32'd1);
    chk("s6_n0_dir", MemDir, 32'h0);
    chk("s6_n0_valida", 32'(InstValida), 32'd0);
    tic();
    chk("s6_n1_valida", 32'(InstValida), 32'd0);
    tic();
    tic();
    chk("s6_n3_valida", 32'(InstValida), 32'd0);
    tic();
    chk("s6_n4_valida", 32'(InstValida), 32'd1);
    chk("s6_n4_pc", InstPC, 32'h0);
    chk("s6_n4_inst", Inst, 32'hA5A5_0000);

    // PC wrap-around
    reinicia(1);
    MemAck = 1'b0;
    Salto = 1'b1;
    DirSalto = 32'hFFFF_FFF8;
    tic();
    Salto = 1'b0;
    MemAck = 1'b1;
    chk("s7_c1_dir", MemDir, 32'hFFFF_FFF8);
    tic();
    tic();
    chk("s7_c3_dir", MemDir, 32'h0);
    chk("s7_c3_pc", InstPC, 32'hFFFF_FFF8);
    chk("s7_c3_inst", Inst, 32'h5A5A_FFF8);
    tic();
    chk("s7_c4_pc", InstPC, 32'hFFFF_FFFC);
    tic();
    chk("s7_c5_pc", InstPC, 32'h0);
    chk("s7_c5_inst", Inst, 32'hA5A5_0000);
    tic();
    chk("s7_c6_pc", InstPC, 32'h4);

    $display("%0d/%0d checks passed", n_total - n_fallos, n_total);
    $finish;
  end

endmodule

// File: doc/etapa_busqueda.md
# etapa_busqueda

Instruction fetch stage feeding the single-cycle datapath's decode/execute logic. It owns the program counter and issues in-order fetch requests to a variable-latency instruction memory. Returned words are buffered in a small FIFO and presented to decode with a valid/ready handshake. A taken branch/jump redirects the PC, flushes buffered instructions and silently discards in-flight stale responses.

## Interface
- ANCHO, 32, data and address width
- PROF, 4, instruction FIFO depth (power of 2, ≥2); also max outstanding fetches + buffered words
- PC_RESET, 32'h0000_0000, PC value after reset
- CLK  in  1  clock, rising edge
- RSTn  in  1  reset, asynchronous, active-low
- MemReq  out  1  fetch request valid
- MemDir  out  ANCHO  fetch address (current PC)
- MemAck  in  1  request accepted this cycle (when MemReq=1)
- MemValido  in  1  response valid; responses return in order, ≥1 cycle after accept
- MemDato  in  ANCHO  response instruction word
- Salto  in  1  redirect request (1-cycle pulse)
- DirSalto  in  ANCHO  redirect target
- InstValida  out  1  Inst/InstPC valid to decode
- Inst  out  ANCHO  instruction word
- InstPC  out  ANCHO  address of Inst
- InstListo  in  1  decode consumes head when InstValida=1

## Operation
- Registers: pc (next fetch addr), pc_resp (addr of next accepted response), pendientes (0..PROF), descartar (0..PROF), FSM state, FIFO of {word, pc}.
- FSM states: BUSCA, DRENA. Reset → BUSCA.
- BUSCA: MemReq = (ocupacion + pendientes < PROF). MemDir = pc. MemReq&MemAck → pc += 4, pendientes += 1.
- BUSCA, MemValido → push {MemDato, pc_resp}, pc_resp += 4, pendientes −= 1. Credit rule guarantees no overflow.
- InstValida & InstListo → pop head.
- Salto (either state): pc ← DirSalto, pc_resp ← DirSalto, FIFO flushed (simultaneous pop/push ignored). Stale count S = pendientes + (MemReq&MemAck) − MemValido, evaluated that cycle. S>0 → descartar ← S, pendientes ← 0, state DRENA. S=0 → BUSCA.
- DRENA: MemReq=0. Each MemValido discarded, descartar −= 1; when it reaches 0 → BUSCA next cycle. Salto in DRENA updates pc/pc_resp only; descartar keeps decrementing normally.
- MemValido with pendientes=0 and descartar=0: protocol error, ignored.
- Inst and InstPC read 0 whenever InstValida=0.
- Arithmetic: PC increments modulo 2^ANCHO (0xFFFF_FFFC + 4 → 0). DirSalto taken verbatim, no alignment check.

## Timing
- Reset (RSTn low, immediate): MemReq=0, MemDir=PC_RESET, InstValida=0, Inst=0, InstPC=0, pendientes=descartar=0, FIFO empty, state BUSCA.
- First cycle after RSTn rises: MemReq=1, MemDir=PC_RESET.
- Response pushed at edge k → InstValida=1 in cycle k+1 (no bypass). Minimum request-to-decode latency: 2 cycles with 1-cycle memory.
- Sustained throughput 1 instr/cycle when memory returns in 1 cycle and InstListo=1.
- Salto at edge k → FIFO empty and InstValida=0 from cycle k+1; if S=0, MemReq=1 with MemDir=DirSalto in cycle k+1.
- Reset mid-operation (any state): all state cleared asynchronously; late memory responses arriving after reset are treated as protocol errors and ignored.

## Structure
- Package paq_busqueda: state enum {BUSCA, DRENA}, constant INCR_PC = 4, FIFO entry struct {word, pc}.
- Sub-module fifo_inst: synchronous FIFO, PROF×2·ANCHO, push/pop/flush, ocupacion output, async active-low reset; flush has priority over push/pop.
- Top holds the FSM, PC registers and credit/discard counters.

## Test plan
- Reset release, MemAck=1, 1-cycle memory, MemDato=addr^32'hA5A5_0000, InstListo=1 → InstPC 0,4,8,… back-to-back from cycle 2, each Inst matches.
- InstListo=0 → exactly 4 requests (0x0,0x4,0x8,0xC), then MemReq=0; InstListo=1 → MemReq resumes at 0x10, order preserved.
- 3-cycle memory, 2 pending, Salto DirSalto=0x100 → state DRENA, MemReq=0 until 2 stale responses arrive, then MemDir=0x100; first delivered InstPC=0x100, no stale word delivered.
- Salto with pendientes=0, FIFO holding 3 words → InstValida=0 next cycle, MemReq=1 with MemDir=0x200 next cycle, no DRENA.
- Salto in same cycle as MemAck and MemValido with pendientes=1 → S=1, exactly one later response discarded; next delivered InstPC=DirSalto.
- RSTn pulsed low during DRENA → outputs at reset values immediately; after release, MemDir=PC_RESET and stream restarts at PC_RESET.
